// File: rtl/trace_capture.sv
// trace_capture: on-chip trace buffer. A DATA_W-bit probe bus is captured into a
// DEPTH-entry circular RAM around a mask/value trigger, and the frozen window is
// read back by logical index (0 = oldest sample).
//
// Optional feature: define TRACE_QUAL_EN to add the i_qual storage qualifier port.
// Unqualified cycles neither write, advance pointers/counters, nor evaluate the trigger.
//
// Ports:
//   clk           capture clock
//   rst_n         synchronous active-low reset
//   i_qual        storage qualifier (TRACE_QUAL_EN only)
//   i_data        probe bus, sampled every clk
//   i_arm         start capture (ignored while busy)
//   i_abort       cancel capture (wins over i_arm)
//   i_trig_mask   1 = bit takes part in the trigger compare
//   i_trig_value  trigger compare value
//   i_post_cnt    samples stored after the trigger sample, latched at arm
//   o_trig_out    one-cycle pulse the cycle after the trigger sample
//   o_busy        capture in progress
//   o_done        capture complete, buffer frozen
//   o_trig_idx    logical index of the trigger sample (DEPTH-1-post_cnt)
//   i_rd_addr     logical read index
//   o_rd_data     registered read data, one cycle latency
module trace_capture #(
   parameter int DATA_W  = 256,
   parameter int DEPTH_W = 10
) (
   input  logic               clk,
   input  logic               rst_n,
`ifdef TRACE_QUAL_EN
   input  logic               i_qual,
`endif
   input  logic [DATA_W-1:0]  i_data,
   input  logic               i_arm,
   input  logic               i_abort,
   input  logic [DATA_W-1:0]  i_trig_mask,
   input  logic [DATA_W-1:0]  i_trig_value,
   input  logic [DEPTH_W-1:0] i_post_cnt,
   output logic               o_trig_out,
   output logic               o_busy,
   output logic               o_done,
   output logic [DEPTH_W-1:0] o_trig_idx,
   input  logic [DEPTH_W-1:0] i_rd_addr,
   output logic [DATA_W-1:0]  o_rd_data
);
   localparam logic [DEPTH_W-1:0] ONE = 1;
   typedef enum logic [2:0] {S_IDLE, S_PREFILL, S_WAIT, S_POST, S_DONE} state_t;
   state_t              r_state, w_nxt;
   logic [DATA_W-1:0]   r_ram [0:(1<<DEPTH_W)-1];
   logic [DEPTH_W-1:0]  r_wr_ptr, r_start_ptr, r_cnt, r_post, r_trig_idx;
   logic [DATA_W-1:0]   r_rd_data;
   logic                r_trig_out;
   logic                w_q, w_we, w_load, w_trig, w_match;
   logic [DEPTH_W-1:0]  w_pre, w_rd_phys;
`ifdef TRACE_QUAL_EN
   assign w_q = i_qual;
`else
   assign w_q = 1'b1;
`endif
   // DEPTH-1-x is the bitwise complement within DEPTH_W bits
   assign w_pre     = ~r_post;
   assign w_match   = ((i_data ^ i_trig_value) & i_trig_mask) == '0;
   assign w_rd_phys = r_start_ptr + i_rd_addr;
   always_comb begin
      w_nxt  = r_state;
      w_we   = 1'b0;
      w_load = 1'b0;
      w_trig = 1'b0;
      case (r_state)
         S_IDLE, S_DONE: if (i_arm) begin
            w_load = 1'b1;
            w_nxt  = (~i_post_cnt == '0) ? S_WAIT : S_PREFILL;
         end
         S_PREFILL: if (w_q) begin
            w_we  = 1'b1;
            w_nxt = (r_cnt == w_pre - ONE) ? S_WAIT : S_PREFILL;
         end
         S_WAIT: if (w_q) begin
            w_we   = 1'b1;
            w_trig = w_match;
            w_nxt  = !w_match ? S_WAIT : (r_post == '0) ? S_DONE : S_POST;
         end
         S_POST: if (w_q) begin
            w_we  = 1'b1;
            w_nxt = (r_cnt == r_post - ONE) ? S_DONE : S_POST;
         end
         default: w_nxt = S_IDLE;
      endcase
      if (i_abort) begin
         w_nxt  = S_IDLE;
         w_we   = 1'b0;
         w_load = 1'b0;
         w_trig = 1'b0;
      end
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_wr_ptr    <= '0;
         r_start_ptr <= '0;
         r_cnt       <= '0;
         r_post      <= '0;
         r_trig_idx  <= '0;
         r_trig_out  <= 1'b0;
         r_rd_data   <= '0;
      end else begin
         r_state    <= w_nxt;
         r_trig_out <= w_trig;
         // the counter restarts on every state change, so it counts writes within a phase
         r_cnt      <= (w_nxt != r_state) ? '0 : w_we ? r_cnt + ONE : r_cnt;
         r_rd_data  <= r_ram[w_rd_phys];
         if (w_we) r_wr_ptr <= r_wr_ptr + ONE;
         if (w_load) begin
            r_post     <= i_post_cnt;
            r_trig_idx <= ~i_post_cnt;
         end
         // the last write of the window lands this edge; the slot after it is the oldest
         if (w_nxt == S_DONE && r_state != S_DONE) r_start_ptr <= r_wr_ptr + ONE;
      end
   end
   always_ff @(posedge clk) begin
      if (rst_n && w_we) r_ram[r_wr_ptr] <= i_data;
   end
   assign o_trig_out = r_trig_out;
   assign o_busy     = r_state == S_PREFILL || r_state == S_WAIT || r_state == S_POST;
   assign o_done     = r_state == S_DONE;
   assign o_trig_idx = r_trig_idx;
   assign o_rd_data  = r_rd_data;
endmodule

// File: tb/tb_trace_capture.sv
// tb_trace_capture: randomized and directed checks of trace_capture against a sample-list model.
module tb_trace_capture;
   logic       clk, rst_n, i_qual, i_arm, i_abort, o_trig_out, o_busy, o_done;
   logic [7:0] i_data, i_trig_mask, i_trig_value, o_rd_data;
   logic [3:0] i_post_cnt, o_trig_idx, i_rd_addr;
   int         n_chk = 0, n_err = 0;
   trace_capture #(.DATA_W(8), .DEPTH_W(4)) dut (
      .clk(clk),
      .rst_n(rst_n),
`ifdef TRACE_QUAL_EN
      .i_qual(i_qual),
`endif
      .i_data(i_data),
      .i_arm(i_arm),
      .i_abort(i_abort),
      .i_trig_mask(i_trig_mask),
      .i_trig_value(i_trig_value),
      .i_post_cnt(i_post_cnt),
      .o_trig_out(o_trig_out),
      .o_busy(o_busy),
      .o_done(o_done),
      .o_trig_idx(o_trig_idx),
      .i_rd_addr(i_rd_addr),
      .o_rd_data(o_rd_data)
   );
   initial clk = 1'b0;
   always #5 clk = ~clk;
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic arm_only(input logic [7:0] mask, input logic [7:0] value, input logic [3:0] post);
      i_arm = 1'b1;
      i_trig_mask = mask;
      i_trig_value = value;
      i_post_cnt = post;
      tick();
      i_arm = 1'b0;
   endtask
   // Model: list of qualified samples since arm. The trigger is the first match at list
   // position >= pre; the window is the DEPTH samples starting pre before it.
   task automatic capture(input logic [7:0] mask, input logic [7:0] value, input logic [3:0] post,
                          input int mode, input string nm);
      logic [7:0] smp[$];
      logic [7:0] cnt, d;
      logic       q;
      int         trig_at, pre;
      bit         fin, et;
      cnt = 8'd0;
      trig_at = -1;
      fin = 1'b0;
      pre = 15 - int'(post);
      arm_only(mask, value, post);
      chk({nm, "_busy_arm"}, 32'(o_busy), 32'd1);
      chk({nm, "_done_arm"}, 32'(o_done), 32'd0);
      for (int c = 0; c < 2000 && !fin; c++) begin
         d = (mode == 2) ? 8'($urandom) : cnt;
`ifdef TRACE_QUAL_EN
         q = (mode == 1) ? ~cnt[0] : (mode == 2) ? 1'($urandom) : 1'b1;
`else
         q = 1'b1;
`endif
         cnt++;
         i_data = d;
         i_qual = q;
         i_rd_addr = 4'($urandom);
         et = 1'b0;
         if (q) begin
            if (trig_at < 0 && smp.size() >= pre && ((d ^ value) & mask) == 8'd0) begin
               trig_at = smp.size();
               et = 1'b1;
            end
            smp.push_back(d);
         end
         tick();
         fin = trig_at >= 0 && smp.size() == trig_at + int'(post) + 1;
         chk({nm, "_trig_out"}, 32'(o_trig_out), 32'(et));
         chk({nm, "_done"}, 32'(o_done), 32'(fin));
         chk({nm, "_busy"}, 32'(o_busy), 32'(!fin));
      end
      chk({nm, "_completed"}, 32'(fin), 32'd1);
      if (fin) begin
         chk({nm, "_trig_idx"}, 32'(o_trig_idx), 32'(pre));
         for (int i = 0; i < 16; i++) begin
            i_rd_addr = 4'(i);
            i_data = 8'($urandom);
            tick();
            chk({nm, "_rd"}, 32'(o_rd_data), 32'(smp[trig_at - pre + i]));
         end
      end
   endtask
   initial begin
      rst_n = 1'b0;
      i_qual = 1'b1;
      i_arm = 1'b0;
      i_abort = 1'b0;
      i_data = '0;
      i_trig_mask = '0;
      i_trig_value = '0;
      i_post_cnt = '0;
      i_rd_addr = '0;
      tick();
      tick();
      chk("rst_trig_out", 32'(o_trig_out), 32'd0);
      chk("rst_busy", 32'(o_busy), 32'd0);
      chk("rst_done", 32'(o_done), 32'd0);
      chk("rst_trig_idx", 32'(o_trig_idx), 32'd0);
      chk("rst_rd_data", 32'(o_rd_data), 32'd0);
      rst_n = 1'b1;
      i_abort = 1'b1;
      tick();
      i_abort = 1'b0;
      chk("idle_abort_busy", 32'(o_busy), 32'd0);
      capture(8'hFF, 8'h20, 4'd5, 0, "s1");
      capture(8'hFF, 8'h03, 4'd5, 0, "s2");
      capture(8'h00, 8'h00, 4'd15, 0, "s3");
      i_qual = 1'b1;
      arm_only(8'hFF, 8'h20, 4'd5);
      for (int c = 0; c < 35; c++) begin
         i_data = 8'(c);
         tick();
         chk("s4_pre_abort_trig", 32'(o_trig_out), 32'(c == 32));
      end
      chk("s4_in_post_busy", 32'(o_busy), 32'd1);
      i_abort = 1'b1;
      tick();
      i_abort = 1'b0;
      chk("s4_abort_busy", 32'(o_busy), 32'd0);
      chk("s4_abort_done", 32'(o_done), 32'd0);
      i_arm = 1'b1;
      i_abort = 1'b1;
      tick();
      i_arm = 1'b0;
      i_abort = 1'b0;
      chk("s4_armabort_busy", 32'(o_busy), 32'd0);
      chk("s4_armabort_done", 32'(o_done), 32'd0);
      for (int c = 0; c < 40; c++) begin
         i_data = 8'(c);
         tick();
         chk("s4_no_trig", 32'(o_trig_out), 32'd0);
         chk("s4_idle_busy", 32'(o_busy), 32'd0);
      end
      capture(8'hFF, 8'h20, 4'd5, 0, "s4");
      arm_only(8'hFF, 8'h20, 4'd5);
      for (int c = 0; c < 15; c++) begin
         i_data = 8'(c);
         tick();
      end
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("s5_trig_out", 32'(o_trig_out), 32'd0);
      chk("s5_busy", 32'(o_busy), 32'd0);
      chk("s5_done", 32'(o_done), 32'd0);
      chk("s5_trig_idx", 32'(o_trig_idx), 32'd0);
      chk("s5_rd_data", 32'(o_rd_data), 32'd0);
      capture(8'hFF, 8'h20, 4'd5, 0, "s5");
`ifdef TRACE_QUAL_EN
      capture(8'hFF, 8'h20, 4'd5, 1, "s6");
`endif
      for (int r = 0; r < 8; r++)
         capture(8'($urandom) & 8'h07, 8'($urandom), 4'($urandom), 2, "rnd");
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/trace_capture.md
Name: trace_capture

Overview:
- Self-contained, parametrised on-chip trace buffer that supersedes the vendor SignalTap wrapper used for debug.
- Captures a DATA_W-bit probe bus into a DEPTH-entry circular RAM.
- Detects a mask/value trigger and keeps a programmable pre/post-trigger window.
- Exposes the frozen capture through a logical-index read port, so debug logic can read traces without the vendor JTAG tool.

Parameters:
DATA_W, 256, probe/trigger bus width.
DEPTH_W, 10, log2 of buffer depth; DEPTH = 1 << DEPTH_W.

Ports:
clk  in  1  capture clock.
rst_n  in  1  synchronous active-low reset.
data  in  DATA_W  probe bus, sampled every clk.
arm  in  1  start capture (level sampled per cycle).
abort  in  1  cancel capture.
trig_mask  in  DATA_W  1 = bit participates in trigger compare.
trig_value  in  DATA_W  compare value.
post_cnt  in  DEPTH_W  samples stored after the trigger sample; latched at arm.
trig_out  out  1  one-cycle pulse, cycle after the trigger sample.
busy  out  1  high in PREFILL/WAIT_TRIG/POST.
done  out  1  capture complete, buffer frozen.
trig_idx  out  DEPTH_W  logical index of trigger sample = DEPTH-1-post_cnt (latched).
rd_addr  in  DEPTH_W  logical read index, 0 = oldest sample.
rd_data  out  DATA_W  registered read data, 1-cycle latency.

Behaviour:
- Reset (rst_n=0 at clk edge): state IDLE; trig_out, busy, done = 0; trig_idx = 0; rd_data = 0. Write pointer and start pointer are cleared. RAM contents are not cleared. Reset mid-capture abandons the capture without a done pulse.
- Trigger match: ((data ^ trig_value) & trig_mask) == 0. trig_mask = 0 matches every sample.
- pre = DEPTH-1-post_cnt, computed from the latched post_cnt.
- States:
  - IDLE: nothing written. arm -> PREFILL, or WAIT_TRIG if pre == 0. Latch post_cnt and trig_idx.
  - PREFILL: write data at wr_ptr and increment wr_ptr (mod DEPTH) every cycle. Trigger matches are ignored. After pre samples are written -> WAIT_TRIG.
  - WAIT_TRIG: write every cycle. The ring wraps, overwriting the oldest entries. On a match, that sample is the trigger sample, and trig_out pulses the next cycle. Go -> DONE if post_cnt == 0, else POST.
  - POST: write post_cnt further samples, then -> DONE.
  - DONE: no writes. done = 1. start_ptr = wr_ptr (the oldest entry). arm -> re-arm as from IDLE, done cleared the same edge.
- First sample written is the one present on the cycle after arm is sampled.
- A complete capture always holds exactly DEPTH samples: pre pre-trigger samples, then the trigger sample, then post_cnt samples.
- Read: rd_data <= RAM[(start_ptr + rd_addr) mod DEPTH] every cycle, valid 1 cycle after rd_addr. Contents are guaranteed only while done = 1. While busy, rd_data returns in-flight RAM contents (undefined ordering).
- arm while busy is ignored.
- abort in any state -> IDLE with busy = 0 and done = 0.
- abort and arm in the same cycle: abort wins.
- abort in IDLE has no effect.
- Simultaneous write and read of the same physical address: read returns old data.
- RAM is inferred as simple dual-port with registered output. No vendor primitives.

Optional Feature:
- Macro TRACE_QUAL_EN.
- When defined, input port qual (1 bit) is added as the storage qualifier. When qual = 0 in PREFILL/WAIT_TRIG/POST:
  - no RAM write;
  - wr_ptr and counters hold;
  - the trigger is not evaluated.
- State transitions occur only on qualified samples.
- When undefined, there is no qual port, and every cycle is qualified.

Test Plan:
1. Basic window. DATA_W=8, DEPTH_W=4. data = counter 0,1,2.. starting the cycle after arm. mask=0xFF, value=0x20, post_cnt=5 -> one trig_out pulse the cycle after data=0x20. done rises after sample 0x25. trig_idx=10. Read of idx 0..15 returns 0x16..0x25.
2. Prefill masking. Same setup with value=0x03 -> the 0x03 during prefill (samples 0..9) is ignored. Trigger on the wrapped 0x03 (sample 259). Readback 0xF9..0xFF,0x00..0x08.
3. Zero prefill. post_cnt=15, mask=0 -> WAIT_TRIG directly; the first sample triggers. trig_idx=0. Readback equals the first 16 samples.
4. Abort. Assert abort during POST, then arm+abort in the same cycle -> busy=0, done=0, no trig_out thereafter. A later arm alone completes normally.
5. Reset mid-capture. Hold rst_n=0 one cycle in WAIT_TRIG -> all outputs 0 next cycle. A following arm with scenario 1 stimulus reproduces the scenario 1 readback.
6. Qualifier (TRACE_QUAL_EN). qual high on even counter values only, value=0x20, post_cnt=5 -> readback 0x0C,0x0E..0x2A (even values). trig_idx=10.
